// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Optional lock feature is enabled by defining DMARB_LOCK_EN.
package dmem_port_arbiter_pkg;

    typedef logic [31:0] vec32_t;

    // Port indices: CPU load/store stage and debug/DMA loader.
    localparam int PORT_CPU    = 0;
    localparam int PORT_LOADER = 1;

    // Grant-lock tracking states (used only when DMARB_LOCK_EN is defined).
    typedef enum logic [1:0] {
        LOCK_UNLOCKED = 2'd0,
        LOCK_LOCKED0  = 2'd1,
        LOCK_LOCKED1  = 2'd2
    } lock_state_e;

    // Word accesses only: any set low address bit is a misaligned access.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant generator.
// Produces a one-hot (or empty) grant from the request valids and the port
// that won last. With DMARB_LOCK_EN a held lock narrows the grant to the
// lock owner until the hold limit forces a release.
module dmem_port_arbiter_rr_arbiter2
    import dmem_port_arbiter_pkg::*;
(
    input  logic [1:0]  i_valid,
    input  logic        i_last_grant,
`ifdef DMARB_LOCK_EN
    input  lock_state_e i_lock_state,
    input  logic        i_force_release,
`endif
    output logic [1:0]  o_grant
);

    // Round-robin pick, then restrict to the lock owner while a lock is held
    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            // The port that did not win last time gets the grant.
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
`ifdef DMARB_LOCK_EN
        if (!i_force_release) begin
            case (i_lock_state)
                LOCK_LOCKED0: o_grant = {1'b0, i_valid[PORT_CPU]};
                LOCK_LOCKED1: o_grant = {i_valid[PORT_LOADER], 1'b0};
                default:      ;
            endcase
        end
`endif
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// Port 0 is the CPU load/store stage, port 1 the debug/DMA loader. One
// access per cycle, round-robin grant, registered one-cycle response.
// Misaligned accesses are accepted, never write memory, read back 0 and
// flag an error. Defining DMARB_LOCK_EN adds grant locking with a hold
// limit of MAX_LOCK_CYCLES.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0Valid,
    input  logic                  req0Write,
    input  logic [ADDR_WIDTH-1:0] req0Address,
    input  logic [DATA_WIDTH-1:0] req0WData,
    input  logic                  req0Lock,
    output logic                  req0Ready,
    output logic                  resp0Valid,
    output logic [DATA_WIDTH-1:0] resp0RData,
    output logic                  resp0Err,

    input  logic                  req1Valid,
    input  logic                  req1Write,
    input  logic [ADDR_WIDTH-1:0] req1Address,
    input  logic [DATA_WIDTH-1:0] req1WData,
    input  logic                  req1Lock,
    output logic                  req1Ready,
    output logic                  resp1Valid,
    output logic [DATA_WIDTH-1:0] resp1RData,
    output logic                  resp1Err,

    output logic [ADDR_WIDTH-1:0] dmAddress,
    output logic                  dmWriteEnabled,
    output logic [DATA_WIDTH-1:0] dmWriteInput,
    input  logic [DATA_WIDTH-1:0] dmReadResult
);

    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_xfer;
    logic                  w_gport;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_write;
    logic                  w_aligned;

    logic                  r_last_grant;
    logic [1:0]            r_resp_valid;
    logic [1:0]            r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata0;
    logic [DATA_WIDTH-1:0] r_resp_rdata1;

    assign w_valid = {req1Valid, req0Valid};

`ifdef DMARB_LOCK_EN
    localparam int                CNT_W   = $clog2(MAX_LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_LOCK_CYCLES);

    lock_state_e      r_lock_state;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             w_force_release;
    logic             w_lock;

    assign w_lock          = w_gport ? req1Lock : req0Lock;
    // Once the owner has held the grant for the limit, this cycle arbitrates
    // as if unlocked; lastGrant equals the owner so the other port wins.
    assign w_force_release = (r_lock_state != LOCK_UNLOCKED) && (r_lock_cnt == CNT_MAX);

    dmem_port_arbiter_rr_arbiter2 u_arb (
        .i_valid         (w_valid),
        .i_last_grant    (r_last_grant),
        .i_lock_state    (r_lock_state),
        .i_force_release (w_force_release),
        .o_grant         (w_grant)
    );

    // Lock FSM: enter on a locked transfer, leave on unlock, idle owner or hold limit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lock_state <= LOCK_UNLOCKED;
            r_lock_cnt   <= '0;
        end else if ((r_lock_state == LOCK_UNLOCKED) || w_force_release) begin
            if (w_xfer && w_lock) begin
                r_lock_state <= w_gport ? LOCK_LOCKED1 : LOCK_LOCKED0;
                r_lock_cnt   <= CNT_W'(1);
            end else begin
                r_lock_state <= LOCK_UNLOCKED;
                r_lock_cnt   <= '0;
            end
        end else if (w_xfer && w_lock) begin
            // Only the owner can be granted here, so this is the owner holding on.
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
        end else begin
            r_lock_state <= LOCK_UNLOCKED;
            r_lock_cnt   <= '0;
        end
    end
`else
    // Lock inputs and the hold limit have no effect in this build.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{req0Lock, req1Lock, MAX_LOCK_CYCLES};

    dmem_port_arbiter_rr_arbiter2 u_arb (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );
`endif

    assign w_xfer    = |w_grant;
    assign w_gport   = w_grant[PORT_LOADER];
    assign w_addr    = w_gport ? req1Address : req0Address;
    assign w_wdata   = w_gport ? req1WData   : req0WData;
    assign w_write   = w_gport ? req1Write   : req0Write;
    assign w_aligned = is_aligned(w_addr[1:0]);

    assign req0Ready = w_grant[PORT_CPU];
    assign req1Ready = w_grant[PORT_LOADER];

    // Memory sees the granted request; writes are blocked while in reset.
    assign dmAddress      = w_xfer ? w_addr  : '0;
    assign dmWriteInput   = w_xfer ? w_wdata : '0;
    assign dmWriteEnabled = w_xfer && w_write && w_aligned && reset;

    // Remember the most recent winner; idle cycles leave it untouched
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_gport;
        end
    end

    // Capture the one-cycle response of the access accepted this cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_resp_valid  <= 2'b00;
            r_resp_err    <= 2'b00;
            r_resp_rdata0 <= '0;
            r_resp_rdata1 <= '0;
        end else begin
            r_resp_valid  <= w_grant;
            r_resp_err    <= w_grant & {2{~w_aligned}};
            r_resp_rdata0 <= (w_grant[PORT_CPU]    && !w_write && w_aligned) ? dmReadResult : '0;
            r_resp_rdata1 <= (w_grant[PORT_LOADER] && !w_write && w_aligned) ? dmReadResult : '0;
        end
    end

    assign resp0Valid = r_resp_valid[PORT_CPU];
    assign resp1Valid = r_resp_valid[PORT_LOADER];
    assign resp0Err   = r_resp_err[PORT_CPU];
    assign resp1Err   = r_resp_err[PORT_LOADER];
    assign resp0RData = r_resp_rdata0;
    assign resp1RData = r_resp_rdata1;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter with a word-indexed memory stand-in, a
// directed vector table, hand-written reset and lock sequences, and a
// randomized phase checked against a transaction-level reference model.
// Lock expectations follow DMARB_LOCK_EN when it is defined.
module tb_dmem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXL = 4;

    logic          clock;
    logic          reset;
    logic          req0Valid, req0Write, req0Lock, req0Ready;
    logic [AW-1:0] req0Address;
    logic [DW-1:0] req0WData;
    logic          resp0Valid, resp0Err;
    logic [DW-1:0] resp0RData;
    logic          req1Valid, req1Write, req1Lock, req1Ready;
    logic [AW-1:0] req1Address;
    logic [DW-1:0] req1WData;
    logic          resp1Valid, resp1Err;
    logic [DW-1:0] resp1RData;
    logic [AW-1:0] dmAddress;
    logic          dmWriteEnabled;
    logic [DW-1:0] dmWriteInput;
    logic [DW-1:0] dmReadResult;

    dmem_port_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_LOCK_CYCLES (MAXL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req0Valid      (req0Valid),
        .req0Write      (req0Write),
        .req0Address    (req0Address),
        .req0WData      (req0WData),
        .req0Lock       (req0Lock),
        .req0Ready      (req0Ready),
        .resp0Valid     (resp0Valid),
        .resp0RData     (resp0RData),
        .resp0Err       (resp0Err),
        .req1Valid      (req1Valid),
        .req1Write      (req1Write),
        .req1Address    (req1Address),
        .req1WData      (req1WData),
        .req1Lock       (req1Lock),
        .req1Ready      (req1Ready),
        .resp1Valid     (resp1Valid),
        .resp1RData     (resp1RData),
        .resp1Err       (resp1Err),
        .dmAddress      (dmAddress),
        .dmWriteEnabled (dmWriteEnabled),
        .dmWriteInput   (dmWriteInput),
        .dmReadResult   (dmReadResult)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- data memory stand-in ----------------
    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    logic [31:0] mem [0:1023];
    logic        mem_loaded;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (dmWriteEnabled) begin
            mem[dmAddress[11:2]] <= dmWriteInput;
        end
    end
    assign dmReadResult = mem[dmAddress[11:2]];

    // ---------------- reference model ----------------
    typedef struct {
        int          port;   // -1: no response expected
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] model_mem [0:1023];
    int          m_last;     // port that won most recently
    int          m_owner;    // lock owner, -1 when unlocked
    int          m_held;     // grants the owner has taken in this lock run

    int errors;
    int checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_owner = -1;
        m_held  = 0;
        exp_q.delete();
    endtask

    // Which port wins given the valids: -1, 0 or 1.
    function automatic int model_grant(input logic v0, input logic v1);
`ifdef DMARB_LOCK_EN
        if (m_owner >= 0 && m_held < MAXL) begin
            if (m_owner == 0) return v0 ? 0 : -1;
            return v1 ? 1 : -1;
        end
`endif
        if (v0 && v1) return 1 - m_last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_lock_update(input int g, input logic lk);
`ifdef DMARB_LOCK_EN
        if (m_owner >= 0 && m_held < MAXL) begin
            if (g == m_owner && lk) m_held++;
            else begin m_owner = -1; m_held = 0; end
        end else begin
            if (g >= 0 && lk) begin m_owner = g; m_held = 1; end
            else begin m_owner = -1; m_held = 0; end
        end
`else
        if (g > 1 || lk === 1'bx) m_held = 0;
`endif
    endtask

    // Advance the model by one cycle using the currently driven requests.
    task automatic model_step(output int g, output logic [31:0] ea, output logic ewe,
                              output logic [31:0] ewd);
        resp_t       r;
        logic [31:0] a;
        logic [31:0] wd;
        logic        wr;
        logic        lk;
        g     = model_grant(req0Valid, req1Valid);
        r.port = g;
        r.data = 32'h0;
        r.err  = 1'b0;
        ea = 32'h0; ewe = 1'b0; ewd = 32'h0; lk = 1'b0;
        if (g >= 0) begin
            a  = (g == 0) ? req0Address : req1Address;
            wd = (g == 0) ? req0WData   : req1WData;
            wr = (g == 0) ? req0Write   : req1Write;
            lk = (g == 0) ? req0Lock    : req1Lock;
            ea = a; ewd = wd;
            r.err = (a[1:0] != 2'b00);
            if (!r.err && wr) begin
                model_mem[a[11:2]] = wd;
                ewe = 1'b1;
            end else if (!r.err) begin
                r.data = model_mem[a[11:2]];
            end
            m_last = g;
        end
        exp_q.push_back(r);
        model_lock_update(g, lk);
    endtask

    task automatic check_resp();
        resp_t r;
        if (exp_q.size() == 0) begin
            r.port = -1; r.data = 32'h0; r.err = 1'b0;
        end else begin
            r = exp_q.pop_front();
        end
        check("resp0Valid", 32'(resp0Valid), 32'(r.port == 0));
        check("resp0RData", resp0RData, (r.port == 0) ? r.data : 32'h0);
        check("resp0Err",   32'(resp0Err), (r.port == 0) ? 32'(r.err) : 32'h0);
        check("resp1Valid", 32'(resp1Valid), 32'(r.port == 1));
        check("resp1RData", resp1RData, (r.port == 1) ? r.data : 32'h0);
        check("resp1Err",   32'(resp1Err), (r.port == 1) ? 32'(r.err) : 32'h0);
    endtask

    // ---------------- drivers ----------------
    task automatic drive0(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic l);
        req0Valid = v; req0Write = w; req0Address = a; req0WData = d; req0Lock = l;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic l);
        req1Valid = v; req1Write = w; req1Address = a; req1WData = d; req1Lock = l;
    endtask

    // One model-checked cycle; called at posedge+1 with inputs already driven.
    task automatic run_cycle();
        int          g;
        logic [31:0] ea, ewd;
        logic        ewe;
        #2;
        model_step(g, ea, ewe, ewd);
        check("req0Ready", 32'(req0Ready), 32'(g == 0));
        check("req1Ready", 32'(req1Ready), 32'(g == 1));
        check("dmAddress", dmAddress, ea);
        check("dmWriteEnabled", 32'(dmWriteEnabled), 32'(ewe));
        if (g >= 0) check("dmWriteInput", dmWriteInput, ewd);
        @(posedge clock); #1;
        check_resp();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v0, w0;
        logic [31:0] a0, d0;
        logic        v1, w1;
        logic [31:0] a1, d1;
        logic        e_r0, e_r1, e_we;
        logic [31:0] e_addr;
        logic        e_rv0;
        logic [31:0] e_rd0;
        logic        e_re0;
        logic        e_rv1;
        logic [31:0] e_rd1;
        logic        e_re1;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    int   exp_lock_g [10];

    initial begin
        int          g;
        logic [31:0] ea, ewd;
        logic        ewe;
        resp_t       dropped;

        errors = 0;
        checks = 0;
        mem_loaded = 1'b0;
        reset = 1'b0;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);

        //            v0 w0 a0            d0            v1 w1 a1        d1            r0 r1 we addr          rv0 rd0           re0 rv1 rd1           re1
        vecs[0]  = '{1, 0, 32'h20,       32'h0,        1, 0, 32'h24, 32'h0,        1, 0, 0, 32'h20,       1, 32'h1000_0008, 0, 0, 32'h0,        0};
        vecs[1]  = '{1, 0, 32'h28,       32'h0,        1, 0, 32'h2C, 32'h0,        0, 1, 0, 32'h2C,       0, 32'h0,         0, 1, 32'h1000_000B, 0};
        vecs[2]  = '{1, 0, 32'h30,       32'h0,        1, 0, 32'h34, 32'h0,        1, 0, 0, 32'h30,       1, 32'h1000_000C, 0, 0, 32'h0,        0};
        vecs[3]  = '{1, 0, 32'h38,       32'h0,        1, 0, 32'h3C, 32'h0,        0, 1, 0, 32'h3C,       0, 32'h0,         0, 1, 32'h1000_000F, 0};
        vecs[4]  = '{1, 0, 32'h40,       32'h0,        1, 0, 32'h44, 32'h0,        1, 0, 0, 32'h40,       1, 32'h1000_0010, 0, 0, 32'h0,        0};
        vecs[5]  = '{1, 0, 32'h48,       32'h0,        1, 0, 32'h4C, 32'h0,        0, 1, 0, 32'h4C,       0, 32'h0,         0, 1, 32'h1000_0013, 0};
        vecs[6]  = '{0, 0, 32'h0,        32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,        0, 32'h0,         0, 0, 32'h0,        0};
        vecs[7]  = '{1, 1, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        1, 0, 1, 32'h10,       1, 32'h0,         0, 0, 32'h0,        0};
        vecs[8]  = '{1, 0, 32'h10,       32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h10,       1, 32'hDEADBEEF,  0, 0, 32'h0,        0};
        vecs[9]  = '{0, 0, 32'h0,        32'h0,        1, 1, 32'h22, 32'h1234,     0, 1, 0, 32'h22,       0, 32'h0,         0, 1, 32'h0,        1};
        vecs[10] = '{0, 0, 32'h0,        32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20,       0, 32'h0,         0, 1, 32'h1000_0008, 0};
        vecs[11] = '{1, 0, 32'h13,       32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h13,       1, 32'h0,         1, 0, 32'h0,        0};
        vecs[12] = '{1, 0, 32'hABCD0014, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 32'hABCD0014, 1, 32'h1000_0005, 0, 0, 32'h0,        0};
        vecs[13] = '{0, 0, 32'h0,        32'h0,        1, 1, 32'h24, 32'hCAFEF00D, 0, 1, 1, 32'h24,       0, 32'h0,         0, 1, 32'h0,        0};
        vecs[14] = '{0, 0, 32'h0,        32'h0,        1, 0, 32'h24, 32'h0,        0, 1, 0, 32'h24,       0, 32'h0,         0, 1, 32'hCAFEF00D, 0};
        vecs[15] = '{1, 1, 32'h28,       32'h55AA55AA, 1, 0, 32'h28, 32'h0,        1, 0, 1, 32'h28,       1, 32'h0,         0, 0, 32'h0,        0};
        vecs[16] = '{1, 0, 32'h2C,       32'h0,        1, 0, 32'h28, 32'h0,        0, 1, 0, 32'h28,       0, 32'h0,         0, 1, 32'h55AA55AA, 0};

`ifdef DMARB_LOCK_EN
        exp_lock_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        exp_lock_g = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

        // ---- reset state ----
        @(posedge clock); #1;
        mem_loaded = 1'b1;
        @(posedge clock); #1;
        check("rst_resp0Valid", 32'(resp0Valid), 32'h0);
        check("rst_resp0RData", resp0RData, 32'h0);
        check("rst_resp0Err",   32'(resp0Err), 32'h0);
        check("rst_resp1Valid", 32'(resp1Valid), 32'h0);
        check("rst_resp1RData", resp1RData, 32'h0);
        check("rst_resp1Err",   32'(resp1Err), 32'h0);
        check("rst_dmWriteEnabled", 32'(dmWriteEnabled), 32'h0);
        reset = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < NVEC; i++) begin
            drive0(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0, 1'b0);
            drive1(vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1, 1'b0);
            #2;
            model_step(g, ea, ewe, ewd);
            check($sformatf("vec%0d_req0Ready", i), 32'(req0Ready), 32'(vecs[i].e_r0));
            check($sformatf("vec%0d_req1Ready", i), 32'(req1Ready), 32'(vecs[i].e_r1));
            check($sformatf("vec%0d_dmWriteEnabled", i), 32'(dmWriteEnabled), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_dmAddress", i), dmAddress, vecs[i].e_addr);
            @(posedge clock); #1;
            if (exp_q.size() > 0) dropped = exp_q.pop_front();
            check($sformatf("vec%0d_resp0Valid", i), 32'(resp0Valid), 32'(vecs[i].e_rv0));
            check($sformatf("vec%0d_resp0RData", i), resp0RData, vecs[i].e_rd0);
            check($sformatf("vec%0d_resp0Err", i),   32'(resp0Err), 32'(vecs[i].e_re0));
            check($sformatf("vec%0d_resp1Valid", i), 32'(resp1Valid), 32'(vecs[i].e_rv1));
            check($sformatf("vec%0d_resp1RData", i), resp1RData, vecs[i].e_rd1);
            check($sformatf("vec%0d_resp1Err", i),   32'(resp1Err), 32'(vecs[i].e_re1));
        end

        // ---- reset asserted while a read is pending ----
        drive0(1, 0, 32'h30, 32'h0, 0);
        drive1(0, 0, 32'h0, 32'h0, 0);
        run_cycle();                        // port 0 wins last before reset
        drive0(1, 0, 32'h34, 32'h0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        drive0(1, 1, 32'h30, 32'h7777_7777, 0);
        #1;
        check("wr_in_reset_we", 32'(dmWriteEnabled), 32'h0);
        @(posedge clock); #1;
        check("reset_drop_resp0Valid", 32'(resp0Valid), 32'h0);
        check("reset_drop_resp1Valid", 32'(resp1Valid), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        drive0(1, 0, 32'h30, 32'h0, 0);
        drive1(1, 0, 32'h34, 32'h0, 0);
        #2;
        check("post_reset_req0Ready", 32'(req0Ready), 32'h1);
        check("post_reset_req1Ready", 32'(req1Ready), 32'h0);
        run_cycle();

        // ---- lock hold sequence: port 0 locked continuously, port 1 waiting ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive0(1, 0, 32'h40, 32'h0, 1);
            drive1(1, 0, 32'h44, 32'h0, 0);
            #2;
            check($sformatf("lock%0d_req0Ready", i), 32'(req0Ready), 32'(exp_lock_g[i] == 0));
            check($sformatf("lock%0d_req1Ready", i), 32'(req1Ready), 32'(exp_lock_g[i] == 1));
            model_step(g, ea, ewe, ewd);
            @(posedge clock); #1;
            check_resp();
        end

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 600; i++) begin
            drive0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rand_addr(),
                   $urandom, $urandom_range(0, 1) == 1);
            drive1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rand_addr(),
                   $urandom, $urandom_range(0, 2) == 0);
            run_cycle();
        end

        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        run_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory (combinational read, posedge-write, word-indexed by address bits [11:2]).
- Port 0 is the CPU load/store stage; port 1 is the debug/DMA loader.
- Performs one memory transaction per cycle, grants round-robin, registers read data and returns it with a one-cycle response.
- Sits between the memory stage/loader and the data memory; the data memory itself is unchanged.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width.
- MAX_LOCK_CYCLES, 16, lock hold limit (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0Valid / req1Valid  in  1  request present.
- req0Write / req1Write  in  1  1 = write, 0 = read.
- req0Address / req1Address  in  ADDR_WIDTH  byte address.
- req0WData / req1WData  in  DATA_WIDTH  write data.
- req0Lock / req1Lock  in  1  hold grant; ignored unless DMARB_LOCK_EN.
- req0Ready / req1Ready  out  1  request accepted this cycle (combinational grant).
- resp0Valid / resp1Valid  out  1  response for the request accepted the previous cycle.
- resp0RData / resp1RData  out  DATA_WIDTH  read data (writes return 0).
- resp0Err / resp1Err  out  1  misaligned address (bits [1:0] != 0).
- dmAddress  out  ADDR_WIDTH  to data memory.
- dmWriteEnabled  out  1  to data memory.
- dmWriteInput  out  DATA_WIDTH  to data memory.
- dmReadResult  in  DATA_WIDTH  from data memory.

Behaviour:
- Reset (reset = 0, asynchronous): all resp* outputs = 0; lastGrant = 1, so port 0 wins the first contention; lock state = UNLOCKED.
- Requests and address:
  - A transfer happens when reqNValid && reqNReady.
  - reqNReady is combinational from the valids and arbitration state; it never depends on respN*.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port != lastGrant is granted.
  - lastGrant updates on every accepted transfer.
  - Neither valid: no grant, and lastGrant holds.
- Memory drive:
  - dmAddress, dmWriteInput = granted port's fields.
  - dmWriteEnabled = granted && write && aligned.
  - No grant: dmAddress = 0, dmWriteEnabled = 0.
- Misaligned access:
  - The request is accepted.
  - Write: suppressed.
  - Read: returns 0.
  - respErr = 1 with the response.
- Response latency: exactly 1 cycle after acceptance.
  - respNValid = 1 for one cycle.
  - respNRData = dmReadResult registered at the accept edge for reads, 0 for writes.
  - Back-to-back accepts give consecutive response cycles.
  - No response backpressure: requesters must sink responses.
- Read-after-write:
  - A write accepted in cycle t is visible to a read accepted in cycle t+1 or later.
  - A same-cycle conflict is impossible, since only one access is granted per cycle.
- Outstanding responses during reset:
  - Reset assertion clears any pending response; it is not delivered.
  - No memory write occurs while reset = 0.
- Address width: only bits [11:2] are meaningful to memory; upper bits pass through unchanged.

Optional Feature:
- Macro: DMARB_LOCK_EN.
- With it, states UNLOCKED / LOCKED0 / LOCKED1:
  - UNLOCKED -> LOCKEDn on an accepted transfer from port n with reqNLock = 1.
  - In LOCKEDn, only port n may be granted.
  - LOCKEDn exits to UNLOCKED on the first of:
    - an accepted port-n transfer with lock = 0;
    - port n valid low for a cycle;
    - MAX_LOCK_CYCLES consecutive locked cycles (counter saturates, then forces release and grants the other port if valid).
  - Reset -> UNLOCKED.
- Without it: lock inputs are ignored, there is no state or counter, and arbitration is pure round-robin.

Decomposition:
- Shared package/header (common.vh): Vec32 typedef, PORT_CPU = 0, PORT_LOADER = 1, lock-state enum.
- One sub-module, rr_arbiter2: valids + lastGrant (+ lock state) -> one-hot grant. It is purely combinational.
- The top level owns lastGrant, response registers, the lock FSM and memory muxing.

Test Plan:
- Reset release, then port 0 write 0xDEADBEEF to 0x10; then port 0 read 0x10:
  - Write cycle: req0Ready = 1 and dmWriteEnabled = 1.
  - One cycle after the read is accepted: resp0Valid = 1, resp0RData = 0xDEADBEEF.
- Both ports reading every cycle for 6 cycles:
  - Grants alternate 0, 1, 0, 1, 0, 1 (port 0 first after reset).
  - Each port sees 3 responses with the correct data.
- Port 1 write to 0x22 (misaligned) with data 0x1234:
  - dmWriteEnabled = 0.
  - Next cycle: resp1Valid = 1, resp1Err = 1.
  - A later read of 0x20 returns the prior contents.
- Port 0 read accepted, then reset asserted mid-cycle before the next edge:
  - resp0Valid stays 0.
  - After release, port 0 wins the first contention.
- DMARB_LOCK_EN, MAX_LOCK_CYCLES = 4, port 0 valid + locked continuously, port 1 valid:
  - Port 0 granted for 4 cycles.
  - Then port 1 granted exactly once.
  - Port 0 may then relock.
- DMARB_LOCK_EN off, same stimulus: strict alternation, lock ignored.
